// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, oversampling default, RX FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

  localparam int   UART_DATA_BITS   = 8;
  localparam int   UART_OVS_DEFAULT = 16;
  localparam logic UART_IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte stream: head byte, valid (FIFO not empty), ready (consumer pop).
// Latency: n/a (wires only).
// Backpressure: a pop happens on any cycle with valid && ready.
interface uart_rx_if;
  logic [7:0] DataIn;
  logic       valid;
  logic       ready;

  modport master (output DataIn, output valid, input  ready);
  modport slave  (input  DataIn, input  valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty; head read from storage.
// Latency: a push is visible at the output on the next cycle.
// Backpressure: push when full without a pop is dropped (o_drop); pop when empty ignored.
// Ports: clk_xtal/rst, i_push/i_push_dat, i_pop, o_dat, o_empty, o_full, o_drop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two, 2..16
) (
  input  logic             clk_xtal,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop  = i_pop && !o_empty;
  // A pop on the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = i_push && (!o_full || w_pop);
  assign o_drop = i_push && !w_push;

  assign o_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled start/data/stop detection feeding a byte FIFO.
// Latency: valid rises the cycle after the stop-bit sample.
// Backpressure: bytes arriving while the FIFO is full (no pop) are dropped and flag overrun.
// Ports: clk_xtal/rst, baud_div (ticks-1), rx line, rx_bus (DataIn/valid/ready),
//        frame_err/overrun (sticky), clr_err, busy.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OVS        = UART_OVS_DEFAULT
) (
  input  logic          clk_xtal,
  input  logic          rst,
  input  logic [15:0]   baud_div,
  input  logic          rx,
  uart_rx_if.master     rx_bus,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clr_err,
  output logic          busy
);
  localparam int             OSW     = $clog2(OVS);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVS / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVS - 1);
  localparam logic [2:0]     BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic           r_sync1, r_sync2;
  logic [15:0]    r_baud_div, r_baud_cnt;
  uart_rx_state_t r_state, w_next_state;
  logic [OSW-1:0] r_os_cnt;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_frame_err, r_overrun;

  logic w_rx, w_tick;
  logic w_os_clr, w_os_inc, w_bit_shift, w_push, w_frame_bad, w_drop;
  logic w_empty, w_full;

  assign w_rx = r_sync2;
  // >= rather than == so a counter left above a newly captured divisor still wraps.
  assign w_tick = (r_baud_cnt >= r_baud_div);

  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      r_sync1 <= UART_IDLE_LEVEL;
      r_sync2 <= UART_IDLE_LEVEL;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Divisor is frozen for the whole frame once the FSM leaves IDLE.
  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      r_baud_div <= '0;
      r_baud_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE) r_baud_div <= baud_div;
      r_baud_cnt <= w_tick ? 16'd0 : r_baud_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_xtal) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_os_clr     = 1'b0;
    w_os_inc     = 1'b0;
    w_bit_shift  = 1'b0;
    w_push       = 1'b0;
    w_frame_bad  = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_rx) begin
            w_next_state = ST_START;
            w_os_clr     = 1'b1;
          end
        end
        ST_START: begin
          if (r_os_cnt == OS_MID) begin
            w_os_clr     = 1'b1;
            // Line back high at mid start bit: treat as a glitch.
            w_next_state = w_rx ? ST_IDLE : ST_DATA;
          end else begin
            w_os_inc = 1'b1;
          end
        end
        ST_DATA: begin
          if (r_os_cnt == OS_LAST) begin
            w_os_clr    = 1'b1;
            w_bit_shift = 1'b1;
            if (r_bit_cnt == BIT_LAST) w_next_state = ST_STOP;
          end else begin
            w_os_inc = 1'b1;
          end
        end
        ST_STOP: begin
          if (r_os_cnt == OS_LAST) begin
            w_os_clr     = 1'b1;
            // Straight to IDLE so a back-to-back start bit is caught.
            w_next_state = ST_IDLE;
            w_push       = w_rx;
            w_frame_bad  = !w_rx;
          end else begin
            w_os_inc = 1'b1;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_os_clr)      r_os_cnt <= '0;
      else if (w_os_inc) r_os_cnt <= r_os_cnt + 1'b1;

      if (r_state != ST_DATA) r_bit_cnt <= '0;
      else if (w_bit_shift)   r_bit_cnt <= r_bit_cnt + 1'b1;

      // LSB first: each new bit enters at the top and shifts down.
      if (w_bit_shift) r_shift <= {w_rx, r_shift[7:1]};
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_xtal   (clk_xtal),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (r_shift),
    .i_pop      (rx_bus.ready),
    .o_dat      (rx_bus.DataIn),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_drop     (w_drop)
  );

  // Error set takes priority over a simultaneous clear.
  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_bad)  r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
      if (w_drop)       r_overrun   <= 1'b1;
      else if (clr_err) r_overrun   <= 1'b0;
    end
  end

  assign rx_bus.valid = !w_empty;
  assign frame_err    = r_frame_err;
  assign overrun      = r_overrun;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: baud_div=0 (16 clocks per bit), 8N1 frames.
// Latency: frame timing is cycle-exact relative to the first start-bit clock.
// Backpressure: ready driven per scenario, including a single-cycle pop on a full push.
module tb_uart_rx;
  logic        clk_xtal = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx;
  logic        clr_err;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  always #5 clk_xtal = ~clk_xtal;

  uart_rx_if u_if ();

  uart_rx #(.FIFO_DEPTH(4), .OVS(16)) dut (
    .clk_xtal  (clk_xtal),
    .rst       (rst),
    .baud_div  (baud_div),
    .rx        (rx),
    .rx_bus    (u_if.master),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .busy      (busy)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         vcnt = 0;
  int         bcnt = 0;
  int         v0, b0;
  logic [7:0] last_dat = 8'h00;

  // Running counts of valid and busy cycles, sampled away from the active edge.
  always @(negedge clk_xtal) begin
    if (u_if.valid === 1'b1) begin
      vcnt     = vcnt + 1;
      last_dat = u_if.DataIn;
    end
    if (busy === 1'b1) bcnt = bcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_xtal);
      #1;
    end
  endtask

  // One 160-cycle frame. pop_at >= 0 drives ready high only on that cycle;
  // rst_at >= 0 pulses rst at that cycle and abandons the frame with the line idle.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int pop_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int c = 0; c < 160; c++) begin
      rx = fr[c / 16];
      if (pop_at >= 0) u_if.ready = (c == pop_at);
      if (c == rst_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk_xtal);
        #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk_xtal);
      #1;
    end
    rx = 1'b1;
    if (pop_at >= 0) u_if.ready = 1'b0;
  endtask

  task automatic pop_one();
    u_if.ready = 1'b1;
    @(posedge clk_xtal);
    #1;
    u_if.ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rx         = 1'b1;
    clr_err    = 1'b0;
    baud_div   = 16'd0;
    u_if.ready = 1'b0;
    idle(3);
    rst = 1'b0;

    // Reset state
    chk("rst_valid",  32'(u_if.valid),  32'd0);
    chk("rst_data",   32'(u_if.DataIn), 32'h00);
    chk("rst_ferr",   32'(frame_err),   32'd0);
    chk("rst_ovr",    32'(overrun),     32'd0);
    chk("rst_busy",   32'(busy),        32'd0);
    idle(5);

    // Good frame 0x55, consumer always ready
    u_if.ready = 1'b1;
    v0 = vcnt;
    send_frame(8'h55, 1'b1, -1, -1);
    idle(20);
    chk("f55_vcycles", 32'(vcnt - v0), 32'd1);
    chk("f55_data",    32'(last_dat),  32'h55);
    chk("f55_ferr",    32'(frame_err), 32'd0);
    chk("f55_ovr",     32'(overrun),   32'd0);

    // Framing error on 0xA3, sticky until clr_err
    v0 = vcnt;
    send_frame(8'hA3, 1'b0, -1, -1);
    idle(30);
    chk("fA3_vcycles", 32'(vcnt - v0), 32'd0);
    chk("fA3_ferr",    32'(frame_err), 32'd1);
    idle(50);
    chk("fA3_ferr_held", 32'(frame_err), 32'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("fA3_ferr_clr", 32'(frame_err), 32'd0);
    chk("fA3_ovr",      32'(overrun),   32'd0);

    // Start-bit glitch: 4 low cycles
    v0 = vcnt;
    b0 = bcnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    chk("glitch_busy_len", 32'((bcnt - b0 >= 1) && (bcnt - b0 <= 8)), 32'd1);
    chk("glitch_busy_end", 32'(busy),        32'd0);
    chk("glitch_vcycles",  32'(vcnt - v0),   32'd0);
    chk("glitch_ferr",     32'(frame_err),   32'd0);
    chk("glitch_ovr",      32'(overrun),     32'd0);

    // Overrun: five frames with no consumer
    u_if.ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, -1);
      idle(10);
      if (i == 4) chk("ovr_after4", 32'(overrun), 32'd0);
    end
    chk("ovr_after5", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_pop_valid", 32'(u_if.valid),  32'd1);
      chk("ovr_pop_data",  32'(u_if.DataIn), 32'(i));
      pop_one();
    end
    chk("ovr_empty", 32'(u_if.valid), 32'd0);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, -1, -1);
      idle(10);
    end
    chk("full_valid", 32'(u_if.valid), 32'd1);
    // Stop-bit sample lands on the clock edge ending frame cycle 154.
    send_frame(8'h77, 1'b1, 154, -1);
    idle(10);
    chk("full_pp_ovr", 32'(overrun), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      chk("full_pop_data", 32'(u_if.DataIn), 32'h10 + 32'(i));
      pop_one();
    end
    chk("full_last_valid", 32'(u_if.valid),  32'd1);
    chk("full_last_data",  32'(u_if.DataIn), 32'h77);

    // Reset during data bit 3 of 0xC6, then a clean 0x0F
    send_frame(8'hC6, 1'b1, -1, 70);
    chk("rst_mid_valid", 32'(u_if.valid),  32'd0);
    chk("rst_mid_busy",  32'(busy),        32'd0);
    chk("rst_mid_data",  32'(u_if.DataIn), 32'h00);
    chk("rst_mid_flags", 32'({frame_err, overrun}), 32'd0);
    idle(20);
    u_if.ready = 1'b1;
    v0 = vcnt;
    send_frame(8'h0F, 1'b1, -1, -1);
    idle(20);
    chk("f0F_vcycles", 32'(vcnt - v0), 32'd1);
    chk("f0F_data",    32'(last_dat),  32'h0F);
    chk("f0F_ferr",    32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter OVS, default 16, oversampling ticks per bit.
REQ-003 SHALL have port clk_xtal  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port baud_div  input  16  clk_xtal cycles per oversample tick, minus 1.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port DataIn  output  8  FIFO head byte, valid only while valid=1.
REQ-008 SHALL have port valid  output  1  FIFO not empty.
REQ-009 SHALL have port ready  input  1  consumer pop; a pop occurs on any cycle where valid&&ready.
REQ-010 SHALL have port frame_err  output  1  sticky; a stop bit was sampled low.
REQ-011 SHALL have port overrun  output  1  sticky; a good byte was dropped because the FIFO was full.
REQ-012 SHALL have port clr_err  input  1  one-cycle pulse clearing frame_err and overrun.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 rx SHALL pass through a two-flop synchronizer (both flops reset to 1) before any use.
REQ-015 Tick generator: counter counts 0..baud_div, then wraps to 0. A one-cycle tick occurs on the wrap. baud_div=0 gives a tick every cycle.
REQ-016 baud_div SHALL be captured into a working register only in IDLE; changes mid-frame have no effect until the next frame.
REQ-017 FSM states: IDLE, START, DATA, STOP. All transitions occur only on tick cycles.
REQ-018 IDLE: synced rx=0 on a tick -> START, with os_cnt=0.
REQ-019 START: at os_cnt=OVS/2-1 (mid start bit), rx=0 -> DATA with os_cnt=0 and bit_cnt=0; rx=1 -> IDLE as a glitch, with no flags and no data.
REQ-020 DATA: at os_cnt=OVS-1, sample rx into the shift register LSB-first. After 8 bits -> STOP.
REQ-021 STOP: at os_cnt=OVS-1, sample rx. If 1, push the byte; if 0, set frame_err and discard the byte. Either way -> IDLE on the same tick, so a back-to-back start bit is detected.
REQ-022 valid SHALL assert on the clk_xtal cycle after the push (1-cycle latency from the stop-bit sample).
REQ-023 FIFO SHALL return bytes in arrival order; DataIn SHALL come from the registered head entry.
REQ-024 Push when full with no pop: drop the byte, set overrun, keep FIFO contents.
REQ-025 Push and pop on the same cycle when full: accept both, with no overrun; count stays full.
REQ-026 Pop when empty SHALL be ignored.
REQ-027 Pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH. Full/empty are decided by the MSB compare.
REQ-028 clr_err on the same cycle as a new error: the set wins.

Reset
REQ-029 rst SHALL force FSM=IDLE, os_cnt=0, bit_cnt=0, tick counter=0, FIFO empty, valid=0, DataIn=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no push and no flags. Reception SHALL resume on the first start bit after rst deasserts.

Structure
REQ-031 FSM state encoding and OVS default SHALL live in the shared package uart_pkg, together with existing UART constants.
REQ-032 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH, same clk_xtal/rst), reusable by a later TX buffer.
REQ-033 Target size SHALL be 150-300 lines of RTL in total.

Verification
All scenarios use baud_div=0 (16 clk_xtal cycles per bit) and 8N1 frames, unless stated.
REQ-034 Frame 0x55 with ready=1 -> valid for exactly 1 cycle with DataIn=0x55; frame_err=0 and overrun=0.
REQ-035 Frame 0xA3 with stop bit driven 0 -> valid stays 0, frame_err=1 and held. After a clr_err pulse -> frame_err=0.
REQ-036 rx low for 4 ticks, then high -> busy high for at most 8 ticks and returns to 0; no valid, no flags.
REQ-037 Five frames 0x01..0x05 with ready=0 -> overrun=1 after the fifth. Four pops return 0x01, 0x02, 0x03, 0x04, then valid=0.
REQ-038 FIFO full and ready=1 on the push cycle of 0x77 -> overrun stays 0; 0x77 is read last.
REQ-039 rst pulsed during DATA bit 3 of frame 0xC6 -> valid=0 and busy=0 on the next cycle. A following frame 0x0F is received intact.
